// File: rtl/mod_exp_power_if.sv
// mod_exp_power_if
//   Request/result bundle between a controller and the iterative power unit.
//   Ports (all logic):
//     start  request pulse toward the unit
//     g      32-bit base
//     x      EXP_W-bit exponent
//     exp    64-bit result, all ones on overflow
//     st     result valid (level)
//     busy   computation in progress
//     ovf    result exceeded 64 bits, meaningful while st=1
//   Modports: master drives the request and reads the result; slave is the unit.
interface mod_exp_power_if #(
  parameter int EXP_W = 8
);
  logic             start;
  logic [31:0]      g;
  logic [EXP_W-1:0] x;
  logic [63:0]      exp;
  logic             st;
  logic             busy;
  logic             ovf;

  modport master (
    output start, g, x,
    input  exp, st, busy, ovf
  );

  modport slave (
    input  start, g, x,
    output exp, st, busy, ovf
  );
endinterface

// File: rtl/mod_exp_power.sv
// mod_exp_power
//   Iterative power unit computing exp = g^x with MSB-first square-and-multiply.
//   Every exponent bit costs one square cycle; every set bit adds one multiply
//   cycle. The result and st are held until the next accepted start, so the
//   downstream reducer sees a stable operand for as long as it needs.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   slave side of mod_exp_power_if (start/g/x in, exp/st/busy/ovf out)
module mod_exp_power #(
  parameter int EXP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  mod_exp_power_if.slave  bus
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      base_q, base_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             flag_q, flag_d;
  logic [63:0]      exp_q, exp_d;
  logic             st_q, st_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [63:0]      mul_b;
  logic [127:0]     prod;
  logic             fin;

  // Overflowed results are presented as all ones.
  function automatic logic [63:0] sat_result(input logic [63:0] val, input logic ovf);
    return ovf ? '1 : val;
  endfunction

  // One shared multiplier: squares in SQR, multiplies by the base in MUL.
  assign mul_b = (state_q == MUL) ? {32'd0, base_q} : acc_q;
  assign prod  = {64'd0, acc_q} * {64'd0, mul_b};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    e_d     = e_q;
    idx_d   = idx_q;
    flag_d  = flag_q;
    exp_d   = exp_q;
    st_d    = st_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    fin     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d   = 64'd1;
          base_d  = bus.g;
          e_d     = bus.x;
          idx_d   = IDX_TOP;
          flag_d  = 1'b0;
          st_d    = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d  = prod[63:0];
        flag_d = flag_q | (|prod[127:64]);
        if (e_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          fin = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MUL: begin
        acc_d  = prod[63:0];
        flag_d = flag_q | (|prod[127:64]);
        if (idx_q == '0) begin
          fin = 1'b1;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result is published on the same edge as the last square/multiply.
    if (fin) begin
      exp_d   = sat_result(acc_d, flag_d);
      ovf_d   = flag_d;
      st_d    = 1'b1;
      busy_d  = 1'b0;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      e_q     <= '0;
      idx_q   <= '0;
      flag_q  <= 1'b0;
      exp_q   <= '0;
      st_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      e_q     <= e_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      exp_q   <= exp_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.exp  = exp_q;
  assign bus.st   = st_q;
  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mod_exp_power.sv
// tb_mod_exp_power
//   Bench for mod_exp_power with EXP_W=8: directed boundary cases followed by
//   randomized operands, each checked against a plain-arithmetic power model
//   (repeated multiplication with 64-bit overflow detection) and the latency
//   rule EXP_W + popcount(x).
module tb_mod_exp_power;

  localparam int EXP_W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [63:0] prev_exp;

  mod_exp_power_if #(.EXP_W(EXP_W)) bus ();

  mod_exp_power #(.EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // g^x by repeated multiplication; overflow as soon as the true value needs more than 64 bits.
  function automatic void model(input logic [31:0] gv, input logic [EXP_W-1:0] xv,
                                output logic [63:0] r, output logic o);
    logic [127:0] v;
    v = 128'd1;
    o = 1'b0;
    for (int i = 0; i < int'(xv); i++) begin
      v = v * {96'd0, gv};
      if (v[127:64] != 64'd0) begin
        o = 1'b1;
        break;
      end
    end
    r = o ? 64'hFFFF_FFFF_FFFF_FFFF : v[63:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation from the posedge+1 phase; optionally re-pulse start
  // while busy after repulse_at edges. Returns in the posedge+1 phase.
  task automatic do_op(input logic [31:0] gv, input logic [EXP_W-1:0] xv,
                       input int repulse_at, input string tag);
    logic [63:0] er;
    logic        eo;
    int          lat;
    int          n;
    bit          got;
    model(gv, xv, er, eo);
    lat = EXP_W + $countones(xv);
    chk({tag, " idle before start"}, 64'(bus.busy), 64'd0);
    bus.g     = gv;
    bus.x     = xv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, " st low after start"}, 64'(bus.st), 64'd0);
    chk({tag, " busy after start"}, 64'(bus.busy), 64'd1);
    chk({tag, " exp held after start"}, bus.exp, prev_exp);
    got = 1'b0;
    n   = 0;
    while (!got && n < lat + 4) begin
      if (n == repulse_at) begin
        bus.g     = 32'd3;
        bus.x     = EXP_W'(200);
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      n++;
      if (bus.st === 1'b1) got = 1'b1;
    end
    chk({tag, " st"}, 64'(bus.st), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " exp"}, bus.exp, er);
    chk({tag, " ovf"}, 64'(bus.ovf), 64'(eo));
    chk({tag, " busy done"}, 64'(bus.busy), 64'd0);
    prev_exp = er;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    prev_exp  = 64'd0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.g     = 32'd0;
    bus.x     = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset exp", bus.exp, 64'd0);
    chk("reset st", 64'(bus.st), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    do_op(32'd5, 8'd3, -1, "g5x3");
    repeat (2) @(posedge clk);
    #1;
    chk("hold st", 64'(bus.st), 64'd1);
    chk("hold exp", bus.exp, 64'd125);
    do_op(32'd2, 8'd63, -1, "g2x63");
    chk("g2x63 value", bus.exp, 64'h8000_0000_0000_0000);
    do_op(32'd2, 8'd64, -1, "g2x64");
    do_op(32'd7, 8'd0, -1, "g7x0");
    do_op(32'd0, 8'd0, -1, "g0x0");
    do_op(32'd0, 8'd5, -1, "g0x5");
    do_op(32'd1, 8'd255, -1, "g1x255");
    do_op(32'hFFFF_FFFF, 8'd2, -1, "gmaxx2");
    do_op(32'hFFFF_FFFF, 8'd3, -1, "gmaxx3");

    // Start while busy is ignored
    do_op(32'd5, 8'd3, 3, "repulse");

    // Reset in the middle of an operation
    bus.g     = 32'd5;
    bus.x     = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst exp", bus.exp, 64'd0);
    chk("midrst st", 64'(bus.st), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    prev_exp = 64'd0;
    do_op(32'd5, 8'd3, -1, "after rst");

    // Randomized operands
    for (int k = 0; k < 30; k++) begin
      logic [31:0]      rg;
      logic [EXP_W-1:0] rx;
      case ($urandom_range(0, 2))
        0: begin
          rg = 32'($urandom_range(0, 20));
          rx = EXP_W'($urandom_range(0, 255));
        end
        1: begin
          rg = 32'($urandom);
          rx = EXP_W'($urandom_range(0, 3));
        end
        default: begin
          rg = 32'($urandom_range(0, 3));
          rx = EXP_W'($urandom_range(0, 70));
        end
      endcase
      do_op(rg, rx, -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
